// File: rtl/snoop_bus_ctrl_pkg.sv
// Shared encodings for the snoop-bus controller: coherence op and controller state.
package snoop_bus_ctrl_pkg;

  typedef enum logic [1:0] {OP_RD, OP_WR, OP_INV} snoop_op_t;

  typedef enum logic [2:0] {IDLE, SNOOP, RESP, MEM_WAIT, DONE} snoop_state_t;

  // One core may raise several ops at once; the strongest one is served.
  function automatic snoop_op_t op_resolve(input logic wr, input logic inv);
    if (inv)     return OP_INV;
    else if (wr) return OP_WR;
    else         return OP_RD;
  endfunction

endpackage

// File: rtl/snoop_bus_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first requester after 'last', wrapping around.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 1; k <= N; k++) begin
      if (!found && req[(int'(last) + k) % N]) begin
        gnt[(int'(last) + k) % N] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_ctrl.sv
// Snoop-bus controller: arbitrates per-core coherence requests, broadcasts snoops,
// steers the winner's line source and issues invalidates to stale copies.
module snoop_bus_ctrl
  import snoop_bus_ctrl_pkg::*;
#(
  parameter int NCPU   = 2,
  parameter int ADDR_W = 11,
  parameter int MEM_TO = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NCPU-1:0]        rd_miss,
  input  logic [NCPU-1:0]        wr_miss,
  input  logic [NCPU-1:0]        inv_req,
  input  logic [NCPU*ADDR_W-1:0] req_addr,
  input  logic [NCPU-1:0]        search_found,
  input  logic                   mem_rdy,
  output logic [NCPU-1:0]        grant,
  output logic [NCPU-1:0]        search,
  output logic [ADDR_W-1:0]      bus_addr,
  output logic [NCPU-1:0]        datasel,
  output logic [NCPU-1:0]        inv_out,
  output logic                   mem_re,
  output logic [NCPU-1:0]        done,
  output logic                   err
);

  localparam int IW = $clog2(NCPU);
  localparam int CW = $clog2(MEM_TO + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(MEM_TO - 1);

  snoop_state_t      state_q, state_d;
  snoop_op_t         op_q, op_d, win_op;
  logic [NCPU-1:0]   grant_q, grant_d, core_req, arb_gnt;
  logic [ADDR_W-1:0] addr_q, addr_d, win_addr;
  logic [IW-1:0]     win_q, win_d, win_idx, last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d, hit_q, hit_d, any_hit;

  assign core_req = rd_miss | wr_miss | inv_req;

  rr_arbiter #(.N(NCPU)) u_arb (
    .req  (core_req),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  always_comb begin
    win_idx  = '0;
    win_op   = OP_RD;
    win_addr = '0;
    for (int i = 0; i < NCPU; i++) begin
      if (arb_gnt[i]) begin
        win_idx  = IW'(i);
        win_op   = op_resolve(wr_miss[i], inv_req[i]);
        win_addr = req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // The winner's own snoop result is meaningless and is masked out.
  assign any_hit = |(search_found & ~grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    win_d   = win_q;
    op_d    = op_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    hit_d   = hit_q;
    unique case (state_q)
      IDLE: begin
        if (|core_req) begin
          grant_d = arb_gnt;
          addr_d  = win_addr;
          win_d   = win_idx;
          op_d    = win_op;
          state_d = SNOOP;
        end
      end
      SNOOP: state_d = RESP;
      RESP: begin
        cnt_d = '0;
        if (op_q == OP_INV) begin
          state_d = DONE;
        end else if (any_hit) begin
          hit_d   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_rdy) begin
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        last_d  = win_q;
        grant_d = '0;
        addr_d  = '0;
        hit_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      last_q  <= IW'(NCPU - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
    op_q  <= op_d;
  end

  assign grant    = grant_q;
  assign bus_addr = addr_q;
  assign err      = err_q;
  assign search   = (state_q == SNOOP) ? ~grant_q : '0;
  assign inv_out  = (state_q == RESP && op_q != OP_RD) ? ~grant_q : '0;
  assign mem_re   = (state_q == MEM_WAIT);
  assign done     = (state_q == DONE) ? grant_q : '0;
  assign datasel  = ((state_q == RESP && op_q != OP_INV && any_hit) ||
                     (state_q == DONE && hit_q)) ? grant_q : '0;

endmodule

// File: tb/tb_snoop_bus_ctrl.sv
// Scoreboard bench for snoop_bus_ctrl with four cores and a short memory timeout.
module tb_snoop_bus_ctrl;

  localparam int NCPU = 4;
  localparam int AW   = 11;
  localparam int TO   = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [3:0]      rd_miss = '0, wr_miss = '0, inv_req = '0, search_found = '0;
  logic [4*AW-1:0] req_addr = '0;
  logic            mem_rdy = 1'b0;
  logic [3:0]      grant, search, datasel, inv_out, done;
  logic [AW-1:0]   bus_addr;
  logic            mem_re, err;

  snoop_bus_ctrl #(.NCPU(NCPU), .ADDR_W(AW), .MEM_TO(TO)) dut (
    .clk(clk), .rst(rst), .rd_miss(rd_miss), .wr_miss(wr_miss), .inv_req(inv_req),
    .req_addr(req_addr), .search_found(search_found), .mem_rdy(mem_rdy),
    .grant(grant), .search(search), .bus_addr(bus_addr), .datasel(datasel),
    .inv_out(inv_out), .mem_re(mem_re), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  dn;
    logic [3:0]  ds;
    logic [10:0] ad;
    int          mr;
    logic [3:0]  iv;
    logic [3:0]  sr;
    int          gc;
    logic        er;
  } exp_t;

  exp_t sb[$];
  logic [10:0] a [4] = '{11'h001, 11'h2AA, 11'h155, 11'h3C3};

  task automatic push(input logic [3:0] dn, input logic [3:0] ds, input int mr,
                      input logic [3:0] iv, input int gc, input logic er);
    exp_t e;
    e.dn = dn; e.ds = ds; e.mr = mr; e.iv = iv; e.sr = ~dn; e.gc = gc; e.er = er;
    e.ad = 11'h000;
    for (int i = 0; i < 4; i++) if (dn[i]) e.ad = a[i];
    sb.push_back(e);
  endtask

  // Monitor: accumulates per-transaction activity and scores it at done.
  logic [3:0] srch_acc, inv_acc;
  int srch_n, inv_n, memre_n, gcyc_n, ds_n;
  exp_t e;

  task automatic clr_acc();
    srch_acc = '0; inv_acc = '0;
    srch_n = 0; inv_n = 0; memre_n = 0; gcyc_n = 0; ds_n = 0;
  endtask

  initial clr_acc();

  always @(negedge clk) begin
    if (rst) begin
      clr_acc();
    end else begin
      if (search != 0)  begin srch_acc |= search; srch_n++; end
      if (inv_out != 0) begin inv_acc |= inv_out; inv_n++; end
      if (datasel != 0) ds_n++;
      if (mem_re)       memre_n++;
      if (grant != 0)   gcyc_n++;
      if (done != 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", done, 4'b0000);
        end else begin
          e = sb.pop_front();
          chk("done",     done,     e.dn);
          chk("grant",    grant,    e.dn);
          chk("datasel",  datasel,  e.ds);
          chk("ds_cycles", ds_n,    (e.ds != 0) ? 2 : 0);
          chk("bus_addr", bus_addr, e.ad);
          chk("err",      err,      e.er);
          chk("mem_re_cycles", memre_n, e.mr);
          chk("grant_cycles",  gcyc_n,  e.gc);
          chk("search",   srch_acc, e.sr);
          chk("search_cycles", srch_n, 1);
          chk("inv_out",  inv_acc,  e.iv);
          chk("inv_cycles", inv_n,  (e.iv != 0) ? 1 : 0);
        end
        clr_acc();
      end
    end
  end

  task automatic wait_done(output int n);
    bit seen = 1'b0;
    n = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (done != 0) begin n = k; seen = 1'b1; end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL done_wait got=none exp=done within 40 cycles");
    end
  endtask

  task automatic wait_mem(output int n);
    bit seen = 1'b0;
    n = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (mem_re) begin n = k; seen = 1'b1; end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL mem_wait got=none exp=mem_re within 40 cycles");
    end
  endtask

  task automatic start(input int c, input logic [2:0] ops, input logic [3:0] sf);
    inv_req[c] = ops[2];
    wr_miss[c] = ops[1];
    rd_miss[c] = ops[0];
    search_found = sf;
  endtask

  task automatic drop_all();
    @(posedge clk); #1;
    rd_miss = '0; wr_miss = '0; inv_req = '0; search_found = '0;
  endtask

  // rdy_at < 0: memory never answers and the timeout must end the wait.
  task automatic mem_phase(input string tag, input int rdy_at);
    int n;
    wait_mem(n);
    if (rdy_at >= 0) begin
      repeat (rdy_at) @(negedge clk);
      mem_rdy = 1'b1;
      @(posedge clk); #1;
      mem_rdy = 1'b0;
      wait_done(n);
      chk({tag, "_rdy_to_done"}, n, 1);
    end else begin
      wait_done(n);
      chk({tag, "_timeout_at"}, n, TO);
    end
  endtask

  task automatic reset_cycle();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    for (int i = 0; i < 4; i++) req_addr[i*AW +: AW] = a[i];
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_grant", grant, 0);   chk("rst_search", search, 0);
    chk("rst_addr", bus_addr, 0); chk("rst_datasel", datasel, 0);
    chk("rst_inv", inv_out, 0);   chk("rst_mem_re", mem_re, 0);
    chk("rst_done", done, 0);     chk("rst_err", err, 0);

    // Core 2 read miss served by core 0's copy.
    @(posedge clk); #1;
    push(4'b0100, 4'b0100, 0, 4'b0000, 3, 1'b0);
    start(2, 3'b001, 4'b0001);
    wait_done(n); chk("t1_latency", n, 4);
    drop_all();

    // Core 1 read miss, only the winner's own bit hits: memory path.
    push(4'b0010, 4'b0000, 6, 4'b0000, 9, 1'b0);
    start(1, 3'b001, 4'b0010);
    wait_mem(n); chk("t2_mem_entry", n, 4);
    repeat (5) @(negedge clk);
    mem_rdy = 1'b1;
    @(posedge clk); #1; mem_rdy = 1'b0;
    wait_done(n); chk("t2_rdy_to_done", n, 1);
    drop_all();

    // Core 3 write miss with a hit in core 1.
    push(4'b1000, 4'b1000, 0, 4'b0111, 3, 1'b0);
    start(3, 3'b010, 4'b0010);
    wait_done(n); chk("t3_latency", n, 4);
    drop_all();

    // Core 0 raises invalidate together with read miss: invalidate wins.
    push(4'b0001, 4'b0000, 0, 4'b1110, 3, 1'b0);
    start(0, 3'b101, 4'b0000);
    wait_done(n); chk("t4_latency", n, 4);
    drop_all();

    // mem_rdy on the last allowed cycle beats the timeout.
    push(4'b0010, 4'b0000, TO, 4'b0000, TO + 3, 1'b0);
    start(1, 3'b001, 4'b0000);
    mem_phase("t5", TO - 1);
    drop_all();

    // Memory never answers.
    push(4'b0100, 4'b0000, TO, 4'b0000, TO + 3, 1'b1);
    start(2, 3'b001, 4'b0000);
    mem_phase("t6", -1);
    drop_all();

    // Still served after a timeout; err stays sticky.
    push(4'b1000, 4'b1000, 0, 4'b0111, 3, 1'b1);
    start(3, 3'b010, 4'b0001);
    wait_done(n); chk("t7_latency", n, 4);
    drop_all();

    // mem_rdy in the very first MEM_WAIT cycle.
    push(4'b0001, 4'b0000, 1, 4'b0000, 4, 1'b1);
    start(0, 3'b001, 4'b0000);
    mem_phase("t8", 0);
    drop_all();

    // Reset mid MEM_WAIT; pointer must return so core 0 beats core 2.
    start(1, 3'b001, 4'b0000);
    wait_mem(n);
    repeat (2) @(negedge clk);
    @(posedge clk); #1; rst = 1'b1; rd_miss = '0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("rst2_grant", grant, 0);   chk("rst2_mem_re", mem_re, 0);
    chk("rst2_err", err, 0);       chk("rst2_addr", bus_addr, 0);
    chk("rst2_done", done, 0);     chk("rst2_search", search, 0);
    @(posedge clk); #1;
    push(4'b0001, 4'b0001, 0, 4'b0000, 3, 1'b0);
    push(4'b0100, 4'b0100, 0, 4'b0000, 3, 1'b0);
    rd_miss = 4'b0101; search_found = 4'b1111;
    wait_done(n);
    @(posedge clk); #1; rd_miss = 4'b0100;
    wait_done(n);
    drop_all();

    // Continuous requests from 0, 1, 3 rotate fairly.
    reset_cycle();
    for (int r = 0; r < 2; r++) begin
      push(4'b0001, 4'b0001, 0, 4'b0000, 3, 1'b0);
      push(4'b0010, 4'b0010, 0, 4'b0000, 3, 1'b0);
      push(4'b1000, 4'b1000, 0, 4'b0000, 3, 1'b0);
    end
    rd_miss = 4'b1011; search_found = 4'b1111;
    for (int t = 0; t < 6; t++) wait_done(n);
    drop_all();

    repeat (5) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snoop_bus_ctrl.md
# snoop_bus_ctrl

Parametrised snoop-bus controller for the multicore: arbitrates line-level coherence requests (read miss, write miss, invalidate) from NCPU cores and broadcasts the line address as a snoop. It collects per-core search hits, steers the requester's line source to either the peer cache or unified memory, and issues invalidates to stale copies. It sits between the cores' coherence ports and unified memory and supersedes the fixed two-core glue.

## Interface
Parameters:
- NCPU, 2, number of cores (2..8)
- ADDR_W, 11, line address width (matches core bus address)
- MEM_TO, 64, cycles before a unified-memory wait is abandoned

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rd_miss  in  NCPU  per-core read-miss request (level)
- wr_miss  in  NCPU  per-core write-miss request (level)
- inv_req  in  NCPU  per-core invalidate/upgrade request (level)
- req_addr  in  NCPU*ADDR_W  per-core line address, core i at [i*ADDR_W +: ADDR_W]
- search_found  in  NCPU  per-core registered snoop hit
- mem_rdy  in  1  unified memory line transfer finished
- grant  out  NCPU  one-hot winner, held for the whole transaction
- search  out  NCPU  snoop strobe to every core except the winner
- bus_addr  out  ADDR_W  latched winner address
- datasel  out  NCPU  to winner: 1 = line from peer cache, 0 = from memory
- inv_out  out  NCPU  invalidate strobe to every non-winner
- mem_re  out  1  unified memory line read request
- done  out  NCPU  one-cycle completion to winner
- err  out  1  sticky: memory timeout seen; cleared only by rst

## Operation
- States: IDLE, SNOOP, RESP, MEM_WAIT, DONE.
- IDLE: requests are sampled only here. core_req[i] = rd_miss|wr_miss|inv_req. Round-robin pick, starting at (last+1) mod NCPU. Latch the winner index, op and address. Per-core op priority: INV > WR_MISS > RD_MISS, so multiple ops from one core resolve to the highest. Go to SNOOP. With no request, stay in IDLE.
- SNOOP (1 cycle): search = ~grant. bus_addr is valid.
- RESP: OR search_found over the non-winners only (the winner's bit is ignored).
  - INV: inv_out = ~grant; go to DONE.
  - WR_MISS: inv_out = ~grant. If any hit, datasel[win]=1 and go to DONE. Else go to MEM_WAIT.
  - RD_MISS: if any hit, datasel[win]=1 and go to DONE. Else go to MEM_WAIT.
- MEM_WAIT: mem_re=1 until mem_rdy. mem_rdy goes to DONE. A counter reaching MEM_TO sets err and goes to DONE.
- DONE: done[win]=1, last=win, go to IDLE. The winner must have dropped its request by the next IDLE cycle.
- rst in any state: go to IDLE, last=NCPU-1 (core 0 wins first), all outputs 0, err=0, timeout counter 0.
- Reset values: every output is 0, and bus_addr=0.

## Timing
- grant and bus_addr are asserted from SNOOP through DONE inclusive. Both are registered.
- Peer-hit path: request seen in IDLE at cycle 0 → SNOOP at 1 → RESP at 2 → done at cycle 3. Total 4 cycles from request to done.
- Memory path: done comes 1 cycle after the mem_rdy cycle. mem_rdy in the same cycle MEM_WAIT is first entered is accepted.
- datasel is held from RESP through DONE. It stays 0 on the memory path.
- inv_out and search are single-cycle strobes.
- A timeout fires on the MEM_TO-th MEM_WAIT cycle without mem_rdy. If mem_rdy and timeout coincide, mem_rdy wins and err is not set.
- Requests arriving outside IDLE are held by the core and arbitrated at the next IDLE.
- A request dropped before IDLE samples it is never seen.

## Structure
- The shared package holds snoop_op_t (OP_RD, OP_WR, OP_INV) and snoop_state_t, next to the existing encodings.
- Sub-module rr_arbiter #(N): inputs req[N] and last index, output one-hot gnt. Purely combinational; the pointer register lives in the parent.
- Timeout counter width is $clog2(MEM_TO+1).

## Test plan
- NCPU=4, core 2 rd_miss, addr 0x155, core 0 search_found=1 in RESP → grant=0100, search=1011, datasel[2]=1, done[2] at cycle 3, mem_re never set.
- Core 1 rd_miss, no hits, mem_rdy 5 cycles after MEM_WAIT entry → mem_re high 6 cycles, done[1] 1 cycle after mem_rdy, datasel=0.
- Cores 0, 1 and 3 all request continuously after reset → grant order 0, 1, 3, 0, 1, 3.
- Core 3 wr_miss with core 1 hit → inv_out=0111 for 1 cycle in RESP, datasel[3]=1. Core 0 inv_req → inv_out=1110, no mem_re, done[0] at cycle 3.
- MEM_TO=8, mem_rdy never arrives → err=1 after 8 MEM_WAIT cycles, done pulses, next request still served. mem_rdy arriving on cycle 8 instead → err stays 0.
- rst asserted during MEM_WAIT → next cycle all outputs 0, err=0. Cores 0 and 2 requesting → core 0 granted first.
